// File: rtl/alu_control_unit.sv
// alu_control_unit: Moore FSM sequencing fetch/decode/execute for the ProjectB datapath
module alu_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic [15:0]      IR,
    output logic             PC_clr,
    output logic             PC_up,
    output logic             IR_ld,
    output logic [7:0]       D_addr,
    output logic             D_wr,
    output logic             RF_s,
    output logic [3:0]       RF_W_addr,
    output logic             RF_W_en,
    output logic [3:0]       RF_Ra_addr,
    output logic [3:0]       RF_Rb_addr,
    output logic [2:0]       ALU_s0,
    output logic [3:0]       OutState,
    output logic [CNT_W-1:0] InstrCount,
    output logic             IllegalOp
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOADA  = 4'd4,
        S_LOADB  = 4'd5,
        S_STORE  = 4'd6,
        S_ALUOP  = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    state_t           state_q, state_d, decode_next;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ill_q, ill_d;
    logic [3:0]       opc;
    logic [2:0]       alu_sel;

    assign opc = IR[15:12];

    // Opcode decode: target execute state and ALU function for arithmetic/logic ops
    always_comb begin
        decode_next = (opc == 4'd0)  ? S_NOOP  :
                      (opc == 4'd1)  ? S_STORE :
                      (opc == 4'd2)  ? S_LOADA :
                      (opc == 4'd5)  ? S_HALT  :
                      (opc >= 4'd11) ? S_NOOP  : S_ALUOP;
        alu_sel     = (opc == 4'd3)  ? 3'd1 :
                      (opc == 4'd4)  ? 3'd2 :
                      (opc == 4'd6)  ? 3'd3 :
                      (opc == 4'd7)  ? 3'd4 :
                      (opc == 4'd8)  ? 3'd5 :
                      (opc == 4'd9)  ? 3'd6 :
                      (opc == 4'd10) ? 3'd7 : 3'd0;
    end

    // Next state, retire counting and sticky illegal-opcode flag
    always_comb begin
        state_d = S_INIT;
        case (state_q)
            S_INIT:                             state_d = S_FETCH;
            S_FETCH:                            state_d = S_DECODE;
            S_DECODE:                           state_d = decode_next;
            S_NOOP, S_STORE, S_LOADB, S_ALUOP:  state_d = S_FETCH;
            S_LOADA:                            state_d = S_LOADB;
            S_HALT:                             state_d = S_HALT;
            default:                            state_d = S_INIT;
        endcase
        cnt_d = (state_q inside {S_NOOP, S_STORE, S_LOADB, S_ALUOP} ||
                 (state_q == S_DECODE && state_d == S_HALT)) ? cnt_q + CNT_W'(1) : cnt_q;
        ill_d = ill_q | (state_q == S_DECODE && opc >= 4'd11);
    end

    // State and status registers, cleared asynchronously by ResetN
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

    // Moore outputs: decoded from current state and instruction fields, zero by default
    always_comb begin
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        IR_ld      = 1'b0;
        D_addr     = 8'd0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = 4'd0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = 4'd0;
        RF_Rb_addr = 4'd0;
        ALU_s0     = 3'd0;
        case (state_q)
            S_INIT:  PC_clr = 1'b1;
            S_FETCH: begin
                IR_ld = 1'b1;
                PC_up = 1'b1;
            end
            S_STORE: begin
                D_addr     = IR[7:0];
                RF_Ra_addr = IR[11:8];
                D_wr       = 1'b1;
            end
            S_LOADA, S_LOADB: begin
                D_addr    = IR[7:0];
                RF_s      = 1'b1;
                RF_W_addr = IR[11:8];
                RF_W_en   = (state_q == S_LOADB);
            end
            S_ALUOP: begin
                RF_Ra_addr = IR[11:8];
                RF_Rb_addr = IR[7:4];
                RF_W_addr  = IR[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = alu_sel;
            end
            default: ;
        endcase
    end

    assign OutState   = state_q;
    assign InstrCount = cnt_q;
    assign IllegalOp  = ill_q;

endmodule
